// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register indices, exception codes, bit-field positions
// and default constants for the coprocessor-0 register block.
package cp0_defs;
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int IP_HI   = 15;
    localparam int IP_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int EXC_HI  = 6;
    localparam int EXC_LO  = 2;

    localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_4180;
    localparam logic [31:0] PRID_DEFAULT         = 32'h2020_1210;

    // EPC always holds a word address; the low two bits are forced to zero.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction
endpackage

// File: rtl/cp0_regfile_int_arb.sv
// Interrupt/exception arbitration: interrupts outrank exceptions and both are
// masked while EXL is set.
module cp0_int_arb
    import cp0_defs::*;
(
    input  logic [5:0] hw_int,
    input  logic [5:0] im,
    input  logic       ie,
    input  logic       exl,
    input  logic       err_in,
    input  logic [4:0] exc_code_in,
    output logic       int_req,
    output logic       req,
    output logic [4:0] exc_code_sel
);
    assign int_req      = (|(hw_int & im)) & ie & ~exl;
    assign req          = int_req | (err_in & ~exl);
    assign exc_code_sel = int_req ? EXC_INT : exc_code_in;
endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register block: SR, Cause, EPC and PRId with mfc0/mtc0/eret
// access from the M stage and a combinational redirect request to the handler.
module cp0_regfile
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID         = PRID_DEFAULT,
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    output logic [31:0] RD,
    input  logic [4:0]  A2,
    input  logic [31:0] WD,
    input  logic        We,
    input  logic        ErrIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic        BDIn,
    input  logic [31:0] EPCIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] HandlerPC,
    output logic [31:0] EPCOut
);
    logic [5:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic        bd_r;
    logic [5:0]  ip_r;
    logic [4:0]  exc_code_r;
    logic [31:0] epc_r;

    logic        int_req_s;
    logic        req_s;
    logic [4:0]  exc_code_sel_s;
    logic [31:0] sr_word_s;
    logic [31:0] cause_word_s;

    cp0_int_arb u_arb (
        .hw_int      (HWInt),
        .im          (im_r),
        .ie          (ie_r),
        .exl         (exl_r),
        .err_in      (ErrIn),
        .exc_code_in (ExcCodeIn),
        .int_req     (int_req_s),
        .req         (req_s),
        .exc_code_sel(exc_code_sel_s)
    );

    assign sr_word_s    = {16'd0, im_r, 8'd0, exl_r, ie_r};
    assign cause_word_s = {bd_r, 15'd0, ip_r, 3'd0, exc_code_r, 2'd0};

    assign Req       = req_s;
    assign HandlerPC = HANDLER_ADDR;
    assign EPCOut    = epc_r;

    // Register state: exception entry has priority over mtc0 and eret, which
    // are being flushed when Req is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            im_r       <= 6'd0;
            exl_r      <= 1'b0;
            ie_r       <= 1'b0;
            bd_r       <= 1'b0;
            ip_r       <= 6'd0;
            exc_code_r <= 5'd0;
            epc_r      <= 32'd0;
        end else begin
            ip_r <= HWInt;
            if (req_s) begin
                exl_r      <= 1'b1;
                exc_code_r <= exc_code_sel_s;
                bd_r       <= BDIn;
                epc_r      <= word_align(EPCIn);
            end else begin
                if (We && (A2 == REG_SR)) begin
                    im_r  <= WD[IM_HI:IM_LO];
                    ie_r  <= WD[IE_BIT];
                    exl_r <= EXLClr ? 1'b0 : WD[EXL_BIT];
                end else if (EXLClr) begin
                    exl_r <= 1'b0;
                end else begin
                    exl_r <= exl_r;
                end
                if (We && (A2 == REG_EPC)) begin
                    epc_r <= word_align(WD);
                end else begin
                    epc_r <= epc_r;
                end
            end
        end
    end

    // mfc0 read port, no bypass from a same-cycle write.
    always_comb begin
        RD = 32'd0;
        case (A1)
            REG_SR:    RD = sr_word_s;
            REG_CAUSE: RD = cause_word_s;
            REG_EPC:   RD = epc_r;
            REG_PRID:  RD = PRID;
            default:   RD = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed plan steps followed by random
// stimulus, compared against a word-level reference model of SR/Cause/EPC.
module tb_cp0_regfile;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  a1;
    logic [31:0] rd;
    logic [4:0]  a2;
    logic [31:0] wd;
    logic        we;
    logic        err_in;
    logic [4:0]  exc_code_in;
    logic        bd_in;
    logic [31:0] epc_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic        req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    cp0_regfile dut (
        .clk(clk), .reset(reset), .A1(a1), .RD(rd), .A2(a2), .WD(wd), .We(we),
        .ErrIn(err_in), .ExcCodeIn(exc_code_in), .BDIn(bd_in), .EPCIn(epc_in),
        .HWInt(hw_int), .EXLClr(exl_clr), .Req(req), .HandlerPC(handler_pc),
        .EPCOut(epc_out)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h2020_1210;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic tick(input bit chk);
        logic [31:0] n_sr, n_cause, n_epc;
        bit ir, rq;
        @(negedge clk);
        ir = ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
        rq = ir || (err_in && !m_sr[1]);
        if (chk) begin
            check32("req", {31'd0, req}, {31'd0, rq});
            check32("rd", rd, exp_rd(a1));
            check32("epc_out", epc_out, m_epc);
            check32("handler_pc", handler_pc, 32'h0000_4180);
        end
        n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
        if (!reset) begin
            n_sr = 32'd0; n_cause = 32'd0; n_epc = 32'd0;
        end else begin
            n_cause[15:10] = hw_int;
            if (rq) begin
                n_sr[1] = 1'b1;
                n_cause[6:2] = ir ? 5'd0 : exc_code_in;
                n_cause[31] = bd_in;
                n_epc = {epc_in[31:2], 2'b00};
            end else begin
                if (we && a2 == 5'd12) n_sr = wd & 32'h0000_FC03;
                if (exl_clr) n_sr[1] = 1'b0;
                if (we && a2 == 5'd14) n_epc = {wd[31:2], 2'b00};
            end
        end
        @(posedge clk);
        m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
        #1;
    endtask

    initial begin
        m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
        reset = 1'b0; a1 = 5'd12; a2 = 5'd0; wd = 32'd0; we = 1'b0;
        err_in = 1'b0; exc_code_in = 5'd0; bd_in = 1'b0; epc_in = 32'd0;
        hw_int = 6'h3F; exl_clr = 1'b0;
        @(posedge clk); #1;
        tick(0); tick(0);
        reset = 1'b1;
        #1;
        check32("reset_sr", rd, 32'd0);
        check32("reset_req", {31'd0, req}, 32'd0);
        check32("reset_epc", epc_out, 32'd0);
        tick(1);
        a1 = 5'd13; #1;
        check32("reset_ip", rd, 32'h0000_FC00);
        a1 = 5'd15; #1;
        check32("prid", rd, 32'h2020_1210);
        tick(1);

        // interrupt path
        hw_int = 6'd0; we = 1'b1; a2 = 5'd12; wd = 32'h0000_0401; a1 = 5'd12;
        tick(1);
        we = 1'b0; hw_int = 6'd1; #1;
        check32("int_req", {31'd0, req}, 32'd1);
        tick(1);
        #1;
        check32("int_masked", {31'd0, req}, 32'd0);
        check32("int_sr", rd, 32'h0000_0403);
        a1 = 5'd13; #1;
        check32("int_cause", rd, 32'h0000_0400);
        tick(1);

        // exception path
        exl_clr = 1'b1; hw_int = 6'd0;
        tick(1);
        exl_clr = 1'b0; err_in = 1'b1; exc_code_in = 5'd12; bd_in = 1'b1; epc_in = 32'h0000_3008;
        #1;
        check32("exc_req", {31'd0, req}, 32'd1);
        tick(1);
        #1;
        check32("exc_cause", rd, 32'h8000_0030);
        check32("exc_epc", epc_out, 32'h0000_3008);
        check32("exl_masks_err", {31'd0, req}, 32'd0);
        tick(1);
        exl_clr = 1'b1;
        tick(1);
        exl_clr = 1'b0; #1;
        check32("err_reassert", {31'd0, req}, 32'd1);
        tick(1);

        // interrupt beats exception, Req beats mtc0
        err_in = 1'b0; exl_clr = 1'b1; we = 1'b1; a2 = 5'd12; wd = 32'h0000_1001;
        tick(1);
        exl_clr = 1'b0; err_in = 1'b1; exc_code_in = 5'd4; hw_int = 6'b000100;
        a2 = 5'd14; wd = 32'h0000_1234; epc_in = 32'h0000_5004; a1 = 5'd13;
        tick(1);
        #1;
        check32("prio_exccode", {27'd0, rd[6:2]}, 32'd0);
        check32("prio_epc", epc_out, 32'h0000_5004);

        // mtc0 EPC alignment and ignored writes
        err_in = 1'b0; we = 1'b0; exl_clr = 1'b1; hw_int = 6'd0;
        tick(1);
        exl_clr = 1'b0; we = 1'b1; a2 = 5'd14; wd = 32'h0000_3003;
        tick(1);
        #1;
        check32("epc_align", epc_out, 32'h0000_3000);
        a2 = 5'd13; wd = 32'hFFFF_FFFF;
        tick(1);
        a2 = 5'd15;
        tick(1);
        we = 1'b0; #1;
        check32("cause_ro", rd, m_cause);
        a1 = 5'd15; #1;
        check32("prid_ro", rd, 32'h2020_1210);
        tick(1);

        // random phase against the model
        for (int i = 0; i < 400; i++) begin
            hw_int      = 6'($urandom);
            err_in      = ($urandom_range(0, 3) == 0);
            exc_code_in = 5'($urandom);
            bd_in       = 1'($urandom);
            epc_in      = $urandom;
            we          = 1'($urandom);
            a2          = 5'($urandom_range(10, 17));
            wd          = $urandom;
            exl_clr     = ($urandom_range(0, 4) == 0);
            a1          = 5'($urandom_range(10, 17));
            tick(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register block for the pipelined MIPS CPU. It is the receiving end of the exception bridge: it takes the bridge's exception request, EPC and exception code, plus hardware interrupt lines.
- It holds SR, Cause, EPC and PRId, and arbitrates interrupt against exception. It raises a one-cycle request that redirects fetch to the handler.
- It serves mfc0/mtc0 reads and writes, and eret, from the M stage.

Parameters:
- PRID, 32'h2020_1210, read-only processor ID value.
- HANDLER_ADDR, 32'h0000_4180, exception entry PC driven on HandlerPC.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising clk.
- A1  in  5  mfc0 read register index.
- RD  out  32  mfc0 read data, combinational from A1.
- A2  in  5  mtc0 write register index.
- WD  in  32  mtc0 write data.
- We  in  1  mtc0 write enable (M stage).
- ErrIn  in  1  exception request from bridge (ErrSignal).
- ExcCodeIn  in  5  exception code from bridge.
- BDIn  in  1  faulting instruction is in a delay slot.
- EPCIn  in  32  return PC from bridge, already delay-slot adjusted.
- HWInt  in  6  external interrupt lines [7:2].
- EXLClr  in  1  eret in M stage.
- Req  out  1  take exception/interrupt this cycle; flush pipeline.
- HandlerPC  out  32  constant HANDLER_ADDR.
- EPCOut  out  32  current EPC register, for eret.

Behaviour:
- SR (index 12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
- Cause (index 13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
- EPC is index 14; PRId is index 15.
- On reset low at a clock edge:
  - SR, Cause and EPC all become 0, so EXL=0, IE=0 and IM=0.
  - Req=0 for the whole following cycle.
- IntReq (internal) = |(HWInt & IM) & IE & ~EXL. It is combinational from the HWInt inputs.
- Req = IntReq | (ErrIn & ~EXL). It is combinational, with zero-cycle latency.
- While EXL=1, both exceptions and interrupts are masked, so Req=0.
- Priority: interrupt beats exception. When both are present, ExcCode is 0 (Int).
- On a clock edge with Req=1:
  - EXL <= 1.
  - ExcCode <= IntReq ? 5'd0 : ExcCodeIn.
  - BD <= BDIn.
  - EPC <= {EPCIn[31:2], 2'b00}.
- IP[15:10] <= HWInt every cycle, unconditionally. It is status only and does not affect Req.
- mtc0, when We=1 and Req=0:
  - A2=12: SR IM/EXL/IE <= the matching WD bits.
  - A2=14: EPC <= {WD[31:2], 2'b00}.
  - A2=13, A2=15 and any other index: the write is ignored.
- Req and We in the same cycle: Req wins and the mtc0 is dropped, because the instruction is being flushed.
- EXLClr=1 with Req=0: EXL <= 0 at the edge.
- EXLClr and Req in the same cycle: Req wins and EXL stays 1. This cannot legally happen, since EXL=1 masks Req, but it must be defined.
- EXLClr together with mtc0 to SR: EXL <= 0 overrides the written EXL bit. The IM and IE bits still take their written values.
- RD is combinational:
  - A1=12/13/14 return the current register value.
  - A1=15 returns PRID.
  - Any other index returns 0.
  - There is no write-to-read bypass: a read in the same cycle as a write returns the old value.
- EPCOut is the registered EPC, with no bypass. A new EPC value is visible the cycle after the write.

Decomposition:
- Shared package cp0_defs holds:
  - register indices SR=12, CAUSE=13, EPC=14, PRID=15;
  - ExcCode constants Int=0, AdEL=4, AdES=5, RI=10, Ov=12;
  - bit-field positions: IM 15:10, IP 15:10, EXL 1, IE 0, BD 31, ExcCode 6:2;
  - HANDLER_ADDR default.
- No sub-module is required. The arbitration logic may be factored as cp0_int_arb, which produces IntReq, Req and the selected ExcCode.

Test Plan:
- Reset 0 for 2 cycles, then 1, with HWInt=6'h3F.
  - RD(12)=0 and RD(13) IP=6'h3F one cycle later; Req=0.
  - RD(15)=32'h2020_1210.
- mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1), then HWInt[0]=1.
  - Same cycle: Req=1.
  - Next cycle: EXL=1, ExcCode=0, Req=0 while HWInt is still held.
- ErrIn=1, ExcCodeIn=12, BDIn=1, EPCIn=32'h0000_3008, EXL=0.
  - Req=1.
  - Next cycle: Cause=32'h8000_0030, EPCOut=32'h0000_3008.
- With EXL=1, assert ErrIn=1: Req stays 0. Then EXLClr=1 for one cycle: EXL=0, and Req reasserts if ErrIn is still held.
- Same cycle: ErrIn=1, ExcCodeIn=4, HWInt[2]=1 with IM[12]=1, IE=1, and We=1 with A2=14, WD=32'h1234.
  - ExcCode=0.
  - EPC=EPCIn, not 32'h1234.
- mtc0 EPC with WD=32'h0000_3003: EPCOut=32'h0000_3000 next cycle. mtc0 to Cause or PRId changes nothing.
